// File: rtl/interval_timer_ctrl_if.sv
// Control/status bundle between a sequencing FSM and the interval timer.
// The master drives the run requests; the slave (the timer) reports progress.
interface interval_timer_ctrl_if #(parameter int N = 4);
    logic         start;
    logic         stop;
    logic         pause;
    logic         repeat_en;
    logic [N-1:0] preset;
    logic [N-1:0] count;
    logic         busy;
    logic         tick;
    logic         done;

    modport master (
        output start, stop, pause, repeat_en, preset,
        input  count, busy, tick, done
    );

    modport slave (
        input  start, stop, pause, repeat_en, preset,
        output count, busy, tick, done
    );
endinterface

// File: rtl/interval_timer_ctrl.sv
// Interval timer: sequences a 74163-style counter from a latched preset up to all-ones,
// then finishes (one-shot) or reloads (repeat), with a registered tick per terminal cycle.
module counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         ld_n,
    input  logic         enp,
    input  logic         ent,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic         rco
);
    always_ff @(posedge clk) begin
        if (!clr_n)
            dout <= '0;
        else if (!ld_n)
            dout <= din;
        else if (enp && ent)
            dout <= dout + 1'b1;
    end

    // Terminal flag qualified by enp, so a held (ent=0) counter can still flag all-ones.
    assign rco = enp && (dout == '1);
endmodule

module interval_timer_ctrl #(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    interval_timer_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t       state;
    logic [N-1:0] preset_q;
    logic         repeat_q;
    logic         busy_q;
    logic         tick_q;
    logic         done_q;

    logic         ld_n;
    logic         enp;
    logic         ent;
    logic         rco;
    logic [N-1:0] dout;

    counter #(.N(N)) u_counter (
        .clk   (clk),
        .clr_n (~clr),
        .ld_n  (ld_n),
        .enp   (enp),
        .ent   (ent),
        .din   (preset_q),
        .dout  (dout),
        .rco   (rco)
    );

    // stop also gates the enables, which keeps rco low and so lets stop beat a terminal cycle.
    always_comb begin
        ld_n = 1'b1;
        enp  = 1'b0;
        ent  = 1'b0;
        case (state)
            LOAD: ld_n = 1'b0;
            RUN: begin
                enp = ~bus.pause & ~bus.stop;
                ent = enp;
                if (rco) begin
                    if (repeat_q)
                        ld_n = 1'b0;
                    else
                        ent = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            preset_q <= '0;
            repeat_q <= 1'b0;
            busy_q   <= 1'b0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tick_q <= (state == RUN) && rco;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        preset_q <= bus.preset;
                        repeat_q <= bus.repeat_en;
                        state    <= LOAD;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (rco && !repeat_q) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.count = dout;
    assign bus.busy  = busy_q;
    assign bus.tick  = tick_q;
    assign bus.done  = done_q;
endmodule

// File: doc/interval_timer_ctrl.md
# interval_timer_ctrl

Programmable interval timer controller that sequences one internal instance of the team's `counter` block (N-bit, 74163-style: synchronous active-low clear, synchronous active-low load, enp/ent count enables, rco terminal flag). It loads a start value, runs the counter up to all-ones, and reports completion with a one-shot or auto-reload pulse train. It sits between the control FSMs of the lab designs and the counter datapath, so those FSMs handle a single start/done handshake instead of raw counter pins.

## Interface
- N, 4, counter width; terminal value M = 2^N-1
- clk  in  1  system clock, all state changes on rising edge
- clr  in  1  reset, synchronous, active-high
- start  in  1  begin a timing run; sampled in IDLE and DONE
- stop  in  1  abort a run; sampled in LOAD and RUN
- pause  in  1  freeze counting while high (RUN only)
- repeat  in  1  auto-reload mode; latched together with preset on accepted start
- preset  in  N  counter start value; latched on accepted start
- count  out  N  counter dout, passed straight through
- busy  out  1  high in LOAD and RUN
- tick  out  1  registered one-cycle pulse, the cycle after each terminal cycle
- done  out  1  level, high while in DONE

## Operation
- Internal counter drive: counter clr input = ~clr; counter din = latched preset.
- States: IDLE, LOAD, RUN, DONE.
- Reset (clr=1 at an edge): state=IDLE, count=0, busy=0, tick=0, done=0, preset/repeat latches=0. clr overrides every other input and state.
- IDLE: counter held (ld_n=1, enp=ent=0). On start=1: latch preset and repeat, go to LOAD.
- LOAD: ld_n=0, so count=preset at the leaving edge. Go to RUN. If stop=1: go to IDLE, and count still takes preset. pause is ignored in LOAD.
- RUN, not terminal: enp=ent=~pause, ld_n=1.
- RUN terminal cycle: count==M, pause=0 and stop=0. Here enp=1, so counter rco=1; rco is the only terminal detector.
  - repeat latch=1: ld_n=0, counter reloads preset (no wrap to 0), stay in RUN.
  - repeat latch=0: enp=1, ent=0, counter holds M, go to DONE.
  - Either way, tick=1 on the next cycle.
- RUN with pause=1: enp=ent=0, count holds, rco=0. A terminal cycle is deferred until pause drops.
- RUN with stop=1: go to IDLE and count holds its current value. stop beats a simultaneous terminal cycle, so no tick is generated. start is ignored in RUN.
- DONE: counter held (count stays M), done=1. start=1 latches new preset/repeat and goes to LOAD; done drops the next cycle. stop is ignored in DONE.
- preset==M: the first RUN cycle is already the terminal cycle. In repeat mode, tick then pulses every cycle.
- Width rules: count is plain N-bit. No wrap-around occurs under controller control; the counter never passes M→0 while the controller is sequencing it.

## Timing
- Accepted start at edge 0 → LOAD during cycle 1 → count=preset from cycle 2.
- Terminal cycle: 2 + (M − preset) + P, where P = number of paused RUN cycles.
- One-shot: done=1 and tick=1 on the cycle after the terminal cycle. tick lasts exactly 1 cycle; done stays high until restart.
- Repeat mode: period between ticks is M − preset + 1 cycles when not paused.
- busy drops, and done rises, on the same edge.
- tick is registered: it never rises combinationally from inputs.
- clr mid-run: outputs take their reset values on the next edge, including tick=0 even if a terminal cycle just occurred.

## Test plan
- Reset, then one-shot, N=4, preset=12, start pulsed cycle 0: count shows 12,13,14,15 in cycles 2–5; cycle 6 has done=1, tick=1, busy=0, count=15; cycle 7 has tick=0, done=1.
- Repeat, preset=13: count cycles 13,14,15,13,14,15…; tick high on cycles 5, 8, 11; done never asserts.
- Pause with preset=14: hold pause=1 for 3 cycles while count=15. rco stays low, count stays 15, and the tick is delayed by exactly 3 cycles. Then repeat with preset=15 in repeat mode: tick on every cycle from cycle 3.
- stop in the terminal cycle (count=15): state goes to IDLE, no tick, count=15, busy=0. stop during LOAD: IDLE with count=preset.
- clr asserted mid-RUN (count=9): next cycle count=0, busy=0, done=0, tick=0. start in DONE with new preset=0: run restarts and done drops in cycle 1.
